// File: rtl/grom_port_master.sv
// GROM port initiator: turns valid/ready commands into gs/m/mo/d strobes paced by
// grclk_en, and returns read bytes as single-cycle rsp_valid pulses.
module grom_port_master (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        grclk_en,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_last,
  output logic        busy,
  output logic        addr_valid,
  output logic        gs,
  output logic        m,
  output logic        mo,
  output logic [7:0]  d,
  input  logic [7:0]  q,
  input  logic        gready,
  output logic [3:0]  dbg_state
);

  // Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
  // cmd_ready is only ever high in IDLE. rsp_valid has no backpressure and is one cycle wide.

  localparam logic [1:0] OP_SET_READ = 2'b00;
  localparam logic [1:0] OP_READ     = 2'b01;
  localparam logic [1:0] OP_READ_ADR = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_AHI    = 4'd1,
    S_ALO    = 4'd2,
    S_RD     = 4'd3,
    S_RDCAP  = 4'd4,
    S_RA1    = 4'd5,
    S_RA1CAP = 4'd6,
    S_RA2    = 4'd7,
    S_RA2CAP = 4'd8,
    S_WD     = 4'd9
  } state_e;

  state_e      state_q;
  logic        ready_q;
  logic        gs_q;
  logic        m_q;
  logic        mo_q;
  logic [7:0]  d_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [8:0]  cnt_q;
  logic        av_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_data_q;
  logic        rsp_last_q;

  // Bus attributes and successor for whichever state owns a strobe.
  logic        stb_active;
  logic        stb_m;
  logic        stb_mo;
  logic [7:0]  stb_d;
  state_e      stb_next;

  always_comb begin
    stb_active = 1'b0;
    stb_m      = 1'b1;
    stb_mo     = 1'b0;
    stb_d      = d_q;
    stb_next   = S_IDLE;
    case (state_q)
      S_AHI: begin
        stb_active = 1'b1;
        stb_m      = 1'b0;
        stb_mo     = 1'b1;
        stb_d      = addr_q[15:8];
        stb_next   = S_ALO;
      end
      S_ALO: begin
        stb_active = 1'b1;
        stb_m      = 1'b0;
        stb_mo     = 1'b1;
        stb_d      = addr_q[7:0];
        stb_next   = S_RD;
      end
      S_RD: begin
        stb_active = 1'b1;
        stb_next   = S_RDCAP;
      end
      S_RA1: begin
        stb_active = 1'b1;
        stb_mo     = 1'b1;
        stb_next   = S_RA1CAP;
      end
      S_RA2: begin
        stb_active = 1'b1;
        stb_mo     = 1'b1;
        stb_next   = S_RA2CAP;
      end
      S_WD: begin
        stb_active = 1'b1;
        stb_m      = 1'b0;
        stb_d      = wdata_q;
        stb_next   = S_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      gs_q        <= 1'b0;
      m_q         <= 1'b1;
      mo_q        <= 1'b0;
      d_q         <= 8'h00;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      cnt_q       <= 9'd0;
      av_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_last_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      if (stb_active) begin
        // A strobe opens only on a grclk_en cycle and closes on the first gready cycle;
        // the closing edge drops gs, so two strobes can never touch.
        if (!gs_q) begin
          if (grclk_en) begin
            gs_q <= 1'b1;
            m_q  <= stb_m;
            mo_q <= stb_mo;
            d_q  <= stb_d;
          end
        end else if (gready) begin
          gs_q    <= 1'b0;
          state_q <= stb_next;
          if (state_q == S_ALO) av_q <= 1'b1;
          if (state_q == S_RA1) av_q <= 1'b0;
          if (state_q == S_WD)  m_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!ready_q) begin
              ready_q <= 1'b1;
            end else if (cmd_valid) begin
              ready_q <= 1'b0;
              addr_q  <= cmd_addr;
              wdata_q <= cmd_wdata;
              cnt_q   <= (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
              case (cmd_op)
                OP_SET_READ: state_q <= S_AHI;
                OP_READ: begin
                  // Without a known pointer a continued read returns one dummy byte.
                  if (av_q) begin
                    state_q <= S_RD;
                  end else begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= 8'h00;
                    rsp_last_q  <= 1'b1;
                  end
                end
                OP_READ_ADR: state_q <= S_RA1;
                default:     state_q <= S_WD;
              endcase
            end
          end
          S_RDCAP: begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= q;
            cnt_q       <= cnt_q - 9'd1;
            if (cnt_q == 9'd1) begin
              rsp_last_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              state_q <= S_RD;
            end
          end
          S_RA1CAP: begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= q;
            state_q     <= S_RA2;
          end
          S_RA2CAP: begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= q;
            rsp_last_q  <= 1'b1;
            mo_q        <= 1'b0;
            state_q     <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready  = ready_q;
  assign busy       = (state_q != S_IDLE);
  assign addr_valid = av_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_last   = rsp_last_q;
  assign gs         = gs_q;
  assign m          = m_q;
  assign mo         = mo_q;
  assign d          = d_q;
  assign dbg_state  = state_q;

endmodule
